// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: PC, IF/ID and ID/EX, with stall, flush and bubble handling.
// Optional performance counters are built when PIPE_FRONT_PERF_CNT_EN is defined.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        stall_D,
    input  logic        flush_E,
    input  logic        pc_src_D,
    input  logic [31:0] pc_branch_D,
    input  logic [31:0] instr_F,
    input  logic        reg_write_D,
    input  logic        mem_to_reg_D,
    input  logic        mem_write_D,
    input  logic        alu_src_D,
    input  logic        reg_dst_D,
    input  logic [2:0]  alu_ctrl_D,
    input  logic [31:0] rd1_D,
    input  logic [31:0] rd2_D,
    input  logic [31:0] sign_imm_D,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] pc_plus4_D,
    output logic [4:0]  rs_D,
    output logic [4:0]  rt_D,
    output logic [4:0]  rd_D,
    output logic        valid_D,
    output logic        reg_write_E,
    output logic        mem_to_reg_E,
    output logic        mem_write_E,
    output logic        alu_src_E,
    output logic        reg_dst_E,
    output logic [2:0]  alu_ctrl_E,
    output logic [31:0] rd1_E,
    output logic [31:0] rd2_E,
    output logic [31:0] sign_imm_E,
    output logic [4:0]  rs_E,
    output logic [4:0]  rt_E,
    output logic [4:0]  rd_E,
    output logic        valid_E,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
);

    logic [31:0] r_pc_F;
    logic [31:0] r_instr_D;
    logic [31:0] r_pc_plus4_D;
    logic        r_valid_D;
    logic [7:0]  r_ctl_E;
    logic [31:0] r_rd1_E;
    logic [31:0] r_rd2_E;
    logic [31:0] r_sign_imm_E;
    logic [14:0] r_regs_E;
    logic        r_valid_E;
    logic [31:0] w_pc_plus4_F;

    assign w_pc_plus4_F = r_pc_F + 32'd4;

    // PC register: hold on stall_F, else redirect or advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_F <= RESET_PC;
        end else if (!stall_F) begin
            r_pc_F <= pc_src_D ? pc_branch_D : w_pc_plus4_F;
        end else begin
            r_pc_F <= r_pc_F;
        end
    end

    // IF/ID register: stall beats the wrong-path flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_D    <= 32'd0;
            r_pc_plus4_D <= 32'd0;
            r_valid_D    <= 1'b0;
        end else if (stall_D) begin
            r_instr_D    <= r_instr_D;
            r_pc_plus4_D <= r_pc_plus4_D;
            r_valid_D    <= r_valid_D;
        end else if (pc_src_D) begin
            r_instr_D    <= 32'd0;
            r_pc_plus4_D <= 32'd0;
            r_valid_D    <= 1'b0;
        end else begin
            r_instr_D    <= instr_F;
            r_pc_plus4_D <= w_pc_plus4_F;
            r_valid_D    <= 1'b1;
        end
    end

    // ID/EX register: never holds, so a stalled D instruction enters E only once
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_E) begin
            r_ctl_E      <= 8'd0;
            r_rd1_E      <= 32'd0;
            r_rd2_E      <= 32'd0;
            r_sign_imm_E <= 32'd0;
            r_regs_E     <= 15'd0;
            r_valid_E    <= 1'b0;
        end else begin
            r_ctl_E      <= {reg_write_D, mem_to_reg_D, mem_write_D, alu_src_D, reg_dst_D, alu_ctrl_D};
            r_rd1_E      <= rd1_D;
            r_rd2_E      <= rd2_D;
            r_sign_imm_E <= sign_imm_D;
            r_regs_E     <= r_instr_D[25:11];
            r_valid_E    <= r_valid_D;
        end
    end

    assign pc_F         = r_pc_F;
    assign instr_D      = r_instr_D;
    assign pc_plus4_D   = r_pc_plus4_D;
    assign valid_D      = r_valid_D;
    assign rs_D         = r_instr_D[25:21];
    assign rt_D         = r_instr_D[20:16];
    assign rd_D         = r_instr_D[15:11];
    assign reg_write_E  = r_ctl_E[7];
    assign mem_to_reg_E = r_ctl_E[6];
    assign mem_write_E  = r_ctl_E[5];
    assign alu_src_E    = r_ctl_E[4];
    assign reg_dst_E    = r_ctl_E[3];
    assign alu_ctrl_E   = r_ctl_E[2:0];
    assign rd1_E        = r_rd1_E;
    assign rd2_E        = r_rd2_E;
    assign sign_imm_E   = r_sign_imm_E;
    assign rs_E         = r_regs_E[14:10];
    assign rt_E         = r_regs_E[9:5];
    assign rd_E         = r_regs_E[4:0];
    assign valid_E      = r_valid_E;

`ifdef PIPE_FRONT_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Stall and bubble counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            r_stall_cnt  <= r_stall_cnt + {31'd0, stall_D};
            r_bubble_cnt <= r_bubble_cnt + {31'd0, (flush_E || (pc_src_D && !stall_D))};
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have stall_F, stall_D, flush_E, input, 1 each, from the hazard unit.
REQ-005 SHALL have pc_src_D, input, 1, taken-branch redirect; pc_branch_D, input, 32, its target.
REQ-006 SHALL have instr_F, input, 32, the instruction-memory word at pc_F.
REQ-007 SHALL have reg_write_D, mem_to_reg_D, mem_write_D, alu_src_D, reg_dst_D, input, 1 each; alu_ctrl_D, input, 3; these are the decoded D controls.
REQ-008 SHALL have rd1_D, rd2_D, sign_imm_D, input, 32 each, the D operands.
REQ-009 SHALL have pc_F, output, 32; instr_D, output, 32; pc_plus4_D, output, 32.
REQ-010 SHALL have rs_D, rt_D, rd_D, output, 5 each, taken from instr_D[25:21], [20:16] and [15:11].
REQ-011 SHALL have *_E outputs mirroring every REQ-007/REQ-008 input, plus rs_E, rt_E, rd_E (5 bits each), valid_D and valid_E (1 bit each).
REQ-012 SHALL have stall_cnt and bubble_cnt, output, 32 each (see Configuration).

Function
REQ-013 PC register: when stall_F=1, SHALL hold its value; otherwise SHALL load pc_branch_D if pc_src_D=1, else pc_F+4.
REQ-014 PC+4 SHALL be computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-015 IF/ID register: when stall_D=1, SHALL hold instr_D, pc_plus4_D and valid_D unchanged, and this SHALL take priority over pc_src_D.
REQ-016 IF/ID register: when stall_D=0 and pc_src_D=1, SHALL clear instr_D to 0, pc_plus4_D to 0 and valid_D to 0 (flush of the wrong-path instruction).
REQ-017 IF/ID register: otherwise SHALL load instr_F, pc_F+4 and valid_D=1.
REQ-018 ID/EX register: when flush_E=1, SHALL clear every *_E output to 0 and set valid_E=0 (bubble), regardless of stall_D.
REQ-019 ID/EX register: otherwise SHALL load all D-stage values, and valid_E SHALL take the value of valid_D.
REQ-020 ID/EX SHALL never hold its value; a held D instruction reaches E only once, after the stall releases.
REQ-021 Latency SHALL be as follows: instr_F appears on instr_D 1 cycle later, and D values appear on the E outputs 1 cycle later.
REQ-022 rs_D, rt_D and rd_D SHALL be purely combinational from instr_D.
REQ-023 A bubble SHALL carry reg_write_E=0, mem_write_E=0 and mem_to_reg_E=0, so it can never trigger forwarding, a write or a load-use stall.

Reset
REQ-024 On rst=1, immediately and asynchronously: pc_F SHALL be RESET_PC; every D/E register, valid_D and valid_E SHALL be 0; counters SHALL be 0.
REQ-025 Reset asserted mid-stall or mid-flush SHALL override both; the first post-reset fetch SHALL be at RESET_PC.
REQ-026 Deassertion SHALL take effect at the first rising clk edge after rst falls.

Configuration
REQ-027 With macro PIPE_FRONT_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 each cycle with stall_D=1, bubble_cnt SHALL increment each cycle with flush_E=1 or with (pc_src_D=1 and stall_D=0), and both SHALL wrap at 2^32.
REQ-028 Without the macro, both ports SHALL remain present, be tied to 0, and no counter flops SHALL exist.

Verification
REQ-029 Reset then 3 free cycles -> pc_F = 0, 4, 8, 12; instr_D lags instr_F by 1 cycle; valid_D rises after the first edge.
REQ-030 Load-use case: stall_F=stall_D=flush_E=1 for 1 cycle -> pc_F and instr_D unchanged, the E controls all 0 with valid_E=0, and the held instruction enters E on the next cycle.
REQ-031 pc_src_D=1 with pc_branch_D=32'h40 -> next pc_F = 32'h40, instr_D = 0 and valid_D = 0; a simultaneous stall_D=1 instead holds pc_F and instr_D.
REQ-032 PC wrap case: force pc_F to 32'hFFFF_FFFC -> the next pc_F = 0.
REQ-033 rst pulsed asynchronously mid-stall -> outputs clear without waiting for a clk edge, and pc_F = RESET_PC.
REQ-034 With PIPE_FRONT_PERF_CNT_EN, 2 stalls + 1 branch flush -> stall_cnt=2 and bubble_cnt=3; without the macro, both read 0.
